// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, FSM
// state encoding and the iteration-counter width helper.
package ex_muldiv_unit_pkg;

   localparam logic [2:0] MDU_MUL    = 3'b000;
   localparam logic [2:0] MDU_MULH   = 3'b001;
   localparam logic [2:0] MDU_MULHSU = 3'b010;
   localparam logic [2:0] MDU_MULHU  = 3'b011;
   localparam logic [2:0] MDU_DIV    = 3'b100;
   localparam logic [2:0] MDU_DIVU   = 3'b101;
   localparam logic [2:0] MDU_REM    = 3'b110;
   localparam logic [2:0] MDU_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } mdu_state_e;

   function automatic int mdu_cnt_w(input int xlen, input int unroll);
      return $clog2(xlen / unroll + 1);
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage <-> multiply/divide unit request/result bundle.
interface ex_muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start_ex;
   logic [2:0]      mdu_code_ex;
   logic [XLEN-1:0] rs1_sel;
   logic [XLEN-1:0] rs2_sel;
   logic [4:0]      rd_adr_ex;
   logic            flush;
   logic            stall;
   logic            mdu_stall;
   logic            busy;
   logic            result_valid;
   logic [XLEN-1:0] result_data;
   logic [4:0]      result_rd_adr;

   modport master (
      output start_ex, mdu_code_ex, rs1_sel, rs2_sel, rd_adr_ex, flush, stall,
      input  mdu_stall, busy, result_valid, result_data, result_rd_adr
   );

   modport slave (
      input  start_ex, mdu_code_ex, rs1_sel, rs2_sel, rd_adr_ex, flush, stall,
      output mdu_stall, busy, result_valid, result_data, result_rd_adr
   );
endinterface

// File: rtl/mdu_iter.sv
// Combinational step of the iterative datapath: retires UNROLL bits of
// shift-add multiply or restoring shift-subtract divide.
module mdu_iter #(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input  logic            i_is_div,
   input  logic [XLEN-1:0] i_acc,
   input  logic [XLEN-1:0] i_lo,
   input  logic [XLEN-1:0] i_opd,
   output logic [XLEN-1:0] o_acc,
   output logic [XLEN-1:0] o_lo
);

   logic [XLEN:0] w_trial;
   logic          w_qbit;

   // Multiply: acc:lo is the product with the multiplier shifting out of lo.
   // Divide: acc is the partial remainder, lo shifts dividend out / quotient in.
   always_comb begin
      o_acc   = i_acc;
      o_lo    = i_lo;
      w_trial = '0;
      w_qbit  = 1'b0;
      for (int k = 0; k < UNROLL; k++) begin
         if (i_is_div) begin
            w_trial = {o_acc, o_lo[XLEN-1]};
            w_qbit  = (w_trial >= {1'b0, i_opd});
            if (w_qbit) begin
               w_trial = w_trial - {1'b0, i_opd};
            end
            o_acc = w_trial[XLEN-1:0];
            o_lo  = {o_lo[XLEN-2:0], w_qbit};
         end else begin
            w_trial = {1'b0, o_acc} + (o_lo[0] ? {1'b0, i_opd} : '0);
            o_acc   = w_trial[XLEN:1];
            o_lo    = {w_trial[0], o_lo[XLEN-1:1]};
         end
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: magnitude iteration, one-cycle sign
// fixup, RISC-V divide corner cases and flush abort; stalls EX while busy.
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int UNROLL = 1
) (
   input logic             clk,
   input logic             rst_n,
   ex_muldiv_unit_if.slave mdu
);

   localparam int              CW      = mdu_cnt_w(XLEN, UNROLL);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e        r_state, w_state_nxt;
   logic [CW-1:0]     r_cnt;
   logic [2:0]        r_code;
   logic [4:0]        r_rd;
   logic [XLEN-1:0]   r_acc, r_lo, r_opd;
   logic              r_neg, r_rneg;
   logic [XLEN-1:0]   r_result;
   logic [4:0]        r_result_rd;

   logic              w_is_div, w_sgn1, w_sgn2, w_div0, w_ovf, w_corner, w_accept;
   logic [XLEN-1:0]   w_mag1, w_mag2, w_corner_res;
   logic [XLEN-1:0]   w_acc_nxt, w_lo_nxt, w_quo, w_rem, w_fix_res;
   logic [2*XLEN-1:0] w_prod, w_prod_fix;

   // Operand decode: MULHU/DIVU/REMU are fully unsigned, MULHSU signs rs1 only.
   assign w_is_div = mdu.mdu_code_ex[2];
   assign w_sgn1   = (w_is_div ? ~mdu.mdu_code_ex[0] : (mdu.mdu_code_ex[1:0] != 2'b11))
                     & mdu.rs1_sel[XLEN-1];
   assign w_sgn2   = (w_is_div ? ~mdu.mdu_code_ex[0] : ~mdu.mdu_code_ex[1])
                     & mdu.rs2_sel[XLEN-1];
   assign w_mag1   = w_sgn1 ? -mdu.rs1_sel : mdu.rs1_sel;
   assign w_mag2   = w_sgn2 ? -mdu.rs2_sel : mdu.rs2_sel;
   assign w_div0   = w_is_div & (mdu.rs2_sel == '0);
   assign w_ovf    = w_is_div & ~mdu.mdu_code_ex[0] & (mdu.rs1_sel == MIN_NEG)
                     & (mdu.rs2_sel == '1);
   assign w_corner = w_div0 | w_ovf;
   assign w_accept = (r_state == ST_IDLE) & mdu.start_ex & ~mdu.flush;

   always_comb begin
      w_corner_res = mdu.rs1_sel;
      if (w_div0 && !mdu.mdu_code_ex[1]) begin
         w_corner_res = '1;
      end else if (w_ovf && mdu.mdu_code_ex[1]) begin
         w_corner_res = '0;
      end
   end

   mdu_iter #(
      .XLEN   (XLEN),
      .UNROLL (UNROLL)
   ) u_mdu_iter (
      .i_is_div (r_code[2]),
      .i_acc    (r_acc),
      .i_lo     (r_lo),
      .i_opd    (r_opd),
      .o_acc    (w_acc_nxt),
      .o_lo     (w_lo_nxt)
   );

   assign w_prod     = {r_acc, r_lo};
   assign w_prod_fix = r_neg ? -w_prod : w_prod;
   assign w_quo      = r_neg ? -r_lo : r_lo;
   assign w_rem      = r_rneg ? -r_acc : r_acc;

   always_comb begin
      case (r_code)
         MDU_MUL:                        w_fix_res = w_prod_fix[XLEN-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
         MDU_DIV, MDU_DIVU:              w_fix_res = w_quo;
         default:                        w_fix_res = w_rem;
      endcase
   end

   always_comb begin
      w_state_nxt       = r_state;
      mdu.busy          = (r_state != ST_IDLE);
      mdu.result_valid  = (r_state == ST_DONE);
      mdu.result_data   = r_result;
      mdu.result_rd_adr = r_result_rd;
      mdu.mdu_stall     = ~mdu.flush & (((r_state == ST_IDLE) & mdu.start_ex)
                                        | (r_state == ST_CALC) | (r_state == ST_FIXUP));
      case (r_state)
         ST_IDLE:  if (w_accept) w_state_nxt = w_corner ? ST_DONE : ST_CALC;
         ST_CALC:  if (r_cnt == CW'(1)) w_state_nxt = ST_FIXUP;
         ST_FIXUP: w_state_nxt = ST_DONE;
         ST_DONE:  if (!mdu.stall) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
      if (mdu.flush) begin
         w_state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_result    <= '0;
         r_result_rd <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_cnt <= CW'(XLEN / UNROLL);
         end else if (r_state == ST_CALC) begin
            r_cnt <= r_cnt - CW'(1);
         end
         // Result registers only load on entry to DONE.
         if (w_state_nxt == ST_DONE && r_state == ST_IDLE) begin
            r_result    <= w_corner_res;
            r_result_rd <= mdu.rd_adr_ex;
         end else if (w_state_nxt == ST_DONE && r_state == ST_FIXUP) begin
            r_result    <= w_fix_res;
            r_result_rd <= r_rd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_code <= mdu.mdu_code_ex;
         r_rd   <= mdu.rd_adr_ex;
         r_acc  <= '0;
         r_opd  <= w_is_div ? w_mag2 : w_mag1;
         r_lo   <= w_is_div ? w_mag1 : w_mag2;
         r_neg  <= w_sgn1 ^ w_sgn2;
         r_rneg <= w_sgn1;
      end else if (r_state == ST_CALC) begin
         r_acc <= w_acc_nxt;
         r_lo  <= w_lo_nxt;
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit (UNROLL 1 and 4 instances) against a 64-bit
// arithmetic reference model of the RV32M operations.
module tb_ex_muldiv_unit;
   import ex_muldiv_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ex_muldiv_unit_if #(.XLEN(32)) if1 ();
   ex_muldiv_unit_if #(.XLEN(32)) if4 ();

   ex_muldiv_unit #(.XLEN(32), .UNROLL(1)) dut1 (.clk(clk), .rst_n(rst_n), .mdu(if1.slave));
   ex_muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (.clk(clk), .rst_n(rst_n), .mdu(if4.slave));

   logic        sel;
   logic        t_start, t_flush, t_stall;
   logic [2:0]  t_code;
   logic [31:0] t_a, t_b;
   logic [4:0]  t_rd;

   assign if1.start_ex    = t_start & ~sel;
   assign if4.start_ex    = t_start & sel;
   assign if1.mdu_code_ex = t_code;
   assign if4.mdu_code_ex = t_code;
   assign if1.rs1_sel     = t_a;
   assign if4.rs1_sel     = t_a;
   assign if1.rs2_sel     = t_b;
   assign if4.rs2_sel     = t_b;
   assign if1.rd_adr_ex   = t_rd;
   assign if4.rd_adr_ex   = t_rd;
   assign if1.flush       = t_flush;
   assign if4.flush       = t_flush;
   assign if1.stall       = t_stall;
   assign if4.stall       = t_stall;

   wire        o_valid = sel ? if4.result_valid  : if1.result_valid;
   wire        o_busy  = sel ? if4.busy          : if1.busy;
   wire        o_mstl  = sel ? if4.mdu_stall     : if1.mdu_stall;
   wire [31:0] o_data  = sel ? if4.result_data   : if1.result_data;
   wire [4:0]  o_rd    = sel ? if4.result_rd_adr : if1.result_rd_adr;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (c)
         MDU_MUL:    begin p = sa * sb; return p[31:0];  end
         MDU_MULH:   begin p = sa * sb; return p[63:32]; end
         MDU_MULHSU: begin p = sa * ub; return p[63:32]; end
         MDU_MULHU:  begin p = ua * ub; return p[63:32]; end
         MDU_DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
         MDU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         MDU_REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
         default:    return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic run_op(input logic u, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         output logic [31:0] res, output logic [4:0] rdo,
                         output int lat, output int stc);
      sel = u; t_code = c; t_a = a; t_b = b; t_rd = rd; t_start = 1'b1;
      lat = 0;
      stc = 0;
      #1;
      while (lat < 200) begin
         if (o_mstl) stc++;
         step();
         lat++;
         if (o_valid) break;
      end
      res = o_data;
      rdo = o_rd;
      t_start = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic u, input logic [2:0] c,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      logic [31:0] res, exp;
      logic [4:0]  rdo;
      int          lat, stc, elat;
      bit          corner;
      exp    = ref_op(c, a, b);
      corner = c[2] && (b == 0 || (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      elat   = corner ? 1 : (u ? 32 / 4 : 32) + 2;
      run_op(u, c, a, b, rd, res, rdo, lat, stc);
      check({tag, " result"}, res, exp);
      check({tag, " rd"}, 32'(rdo), 32'(rd));
      check({tag, " latency"}, 32'(lat), 32'(elat));
      check({tag, " stall cycles"}, 32'(stc), 32'(elat));
      step();
      check({tag, " idle after"}, 32'(o_busy), 32'd0);
   endtask

   initial begin
      logic [31:0] res, a, b;
      logic [4:0]  rdo;
      logic [2:0]  c;
      int          lat, stc, seen, r;

      sel = 1'b0; t_start = 1'b0; t_flush = 1'b0; t_stall = 1'b0;
      t_code = '0; t_a = '0; t_b = '0; t_rd = '0;
      rst_n = 1'b0;
      step();
      step();
      check("reset busy u1",   32'(if1.busy), 0);
      check("reset stall u1",  32'(if1.mdu_stall), 0);
      check("reset valid u1",  32'(if1.result_valid), 0);
      check("reset data u1",   if1.result_data, 0);
      check("reset rd u1",     32'(if1.result_rd_adr), 0);
      check("reset valid u4",  32'(if4.result_valid), 0);
      check("reset data u4",   if4.result_data, 0);
      rst_n = 1'b1;
      step();

      do_op("MUL 7*-3",        0, MDU_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1);
      do_op("MULH min*min",    0, MDU_MULH,   32'h8000_0000,  32'h8000_0000, 5'd2);
      do_op("MULHU min*min",   0, MDU_MULHU,  32'h8000_0000,  32'h8000_0000, 5'd3);
      do_op("MULHSU -1*max",   0, MDU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4);
      do_op("DIV -7/2",        0, MDU_DIV,    32'hFFFF_FFF9,  32'd2,         5'd5);
      do_op("REM -7/2",        0, MDU_REM,    32'hFFFF_FFF9,  32'd2,         5'd6);
      do_op("DIVU max/2",      0, MDU_DIVU,   32'hFFFF_FFFF,  32'd2,         5'd7);
      do_op("DIV 5/0",         0, MDU_DIV,    32'd5,          32'd0,         5'd8);
      do_op("REMU 5/0",        0, MDU_REMU,   32'd5,          32'd0,         5'd9);
      do_op("DIV ovf",         0, MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd10);
      do_op("REM ovf",         0, MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd11);

      // Flush on the 10th CALC cycle.
      sel = 1'b0; t_code = MDU_MUL; t_a = 32'd5; t_b = 32'd6; t_rd = 5'd12; t_start = 1'b1;
      for (int i = 0; i < 10; i++) step();
      t_flush = 1'b1;
      #1;
      check("flush masks mdu_stall", 32'(o_mstl), 0);
      step();
      t_flush = 1'b0;
      t_start = 1'b0;
      check("flush -> idle", 32'(o_busy), 0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (o_valid) seen++;
         step();
      end
      check("no valid after flush", 32'(seen), 0);
      do_op("MUL 3*4 after flush", 0, MDU_MUL, 32'd3, 32'd4, 5'd13);

      // Downstream stall holds DONE.
      run_op(0, MDU_MUL, 32'd9, 32'd11, 5'd14, res, rdo, lat, stc);
      check("stall op result", res, 32'd99);
      t_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall hold valid", 32'(o_valid), 1);
         check("stall hold data", o_data, 32'd99);
         check("DONE mdu_stall low", 32'(o_mstl), 0);
      end
      t_stall = 1'b0;
      step();
      check("stall release idle", 32'(o_busy), 0);
      check("data kept in idle", o_data, 32'd99);

      // Flush coinciding with DONE exit.
      run_op(0, MDU_DIVU, 32'd100, 32'd7, 5'd15, res, rdo, lat, stc);
      check("divu 100/7", res, 32'd14);
      t_flush = 1'b1;
      step();
      t_flush = 1'b0;
      check("flush at DONE idle", 32'(o_busy), 0);
      check("flush at DONE valid", 32'(o_valid), 0);

      // Asynchronous reset in the middle of CALC.
      sel = 1'b0; t_code = MDU_MUL; t_a = 32'd3; t_b = 32'd5; t_rd = 5'd16; t_start = 1'b1;
      for (int i = 0; i < 6; i++) step();
      t_start = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async reset busy", 32'(o_busy), 0);
      check("async reset valid", 32'(o_valid), 0);
      check("async reset data", o_data, 0);
      check("async reset stall", 32'(o_mstl), 0);
      step();
      rst_n = 1'b1;
      step();

      do_op("U4 MUL 3*4",   1, MDU_MUL,  32'd3,          32'd4,         5'd17);
      do_op("U4 DIV -7/2",  1, MDU_DIV,  32'hFFFF_FFF9,  32'd2,         5'd18);
      do_op("U4 REM ovf",   1, MDU_REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd19);

      for (int i = 0; i < 60; i++) begin
         c = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         r = $urandom_range(0, 7);
         if (r == 0) b = 32'd0;
         else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (r == 2) b = $urandom_range(1, 15);
         do_op($sformatf("rnd%0d", i), (i % 3) == 0, c, a, b, 5'($urandom_range(0, 31)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
